keypad_field_entry: RTL and testbench
=====================================

# keypad_field_entry

Parametrised keypad entry engine: debounces the 12-key one-hot keypad and assembles BCD digits into a configurable number of multi-digit fields (e.g. hh:mm:ss, alarm time, date). `#` advances the field and `*` commits the whole set atomically to the output register; entries are aborted by disable or timeout. Sits between the keypad pins and the clock/alarm/LCD logic and replaces the per-mode hard-coded digit capture in `main`.

## Interface
- NUM_FIELDS, 6, number of fields, 1..8
- DIGITS, 2, BCD digits per field, 1..4
- DEBOUNCE, 4, consecutive stable cycles required for press and for release, ≥1
- TIMEOUT, 0, idle cycles in ENTRY before abort; 0 disables
- clk  in  1  system clock; one clock domain
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  1 = accept keys; falling edge aborts an entry in progress
- keypad_in  in  12  one-hot keys: bits 0..8 = digits 1..9, bit 9 = `*`, bit 10 = `0`, bit 11 = `#`
- field_bcd  out  NUM_FIELDS*DIGITS*4  committed fields; field 0 in the LSBs, most significant digit first within each field
- field_idx  out  3  field currently being edited
- busy  out  1  high in ENTRY
- key_strobe  out  1  one-cycle pulse per accepted key
- key_code  out  4  code of the last accepted key: 0..9 = digit, 10 = `*`, 11 = `#`, 15 = none
- commit  out  1  one-cycle pulse when field_bcd updates
- aborted  out  1  one-cycle pulse when an entry is discarded

## Operation
- keypad_in passes through a 2-flop synchroniser. Zero bits set, or more than one bit set, is "no key".
- Debounce FSM: RELEASED → PRESS_WAIT when a valid key appears.
  - PRESS_WAIT → HELD after DEBOUNCE consecutive cycles with an identical code. This fires key_strobe and loads key_code.
  - Any change during PRESS_WAIT returns to RELEASED.
  - HELD → RELEASE_WAIT on "no key"; RELEASE_WAIT → RELEASED after DEBOUNCE consecutive "no key" cycles. A key reappearing returns to HELD with no new strobe.
  - Exactly one strobe per physical press; auto-repeat is not supported.
- Entry FSM: IDLE → ENTRY on the first strobe while enable=1. Strobes are ignored while enable=0.
- Digit key: current working field shifts left by one digit and the new digit enters the LS digit. The oldest digit is discarded.
- `#`: field_idx increments, wrapping from NUM_FIELDS-1 to 0.
- `*`: working buffer is copied to field_bcd and commit pulses. Working buffer clears to 0, field_idx goes to 0, FSM → IDLE.
  - `*` as the first key also commits, which writes all-zero fields.
- Abort: enable falls, or TIMEOUT cycles pass in ENTRY without a strobe. aborted pulses, working buffer clears, field_idx goes to 0, FSM → IDLE. field_bcd is unchanged.
- Simultaneous events:
  - enable falling in the same cycle as a strobe: the abort wins and the key is dropped.
  - Timeout expiring in the same cycle as a strobe: the key wins and the timer reloads.
- Digits are not range-checked; the consumer validates the value (e.g. minutes < 60).

## Timing
- Reset: every output is 0, except key_code = 15. Both FSMs reset to RELEASED/IDLE and all counters to 0. Reset mid-entry discards the entry with no aborted pulse.
- Key latency: keypad_in stable before edge 0 → key_strobe high in the cycle after edge 2+DEBOUNCE.
- Entry state updates on the edge after key_strobe (field_idx, working buffer, commit, aborted, busy). commit and the new field_bcd value appear together.
- Abort on enable falling: aborted pulses in the cycle after enable is sampled low.
- Timeout counter reloads on each strobe and on entry to ENTRY.

## Structure
- Shared package `keypad_pkg` holds:
  - KEY_* code constants (KEY_STAR=10, KEY_HASH=11, KEY_NONE=15).
  - The one-hot-to-code function, which returns KEY_NONE for invalid input.
  - The keypad bit map.
- Sub-module `keypad_debounce` contains the synchroniser, the debounce FSM and the counter, and outputs key_strobe and key_code. It can be reused by the menu/mode logic.
- The top level holds the entry FSM, working buffer, field_idx, output register and timeout counter.

## Test plan
- NUM_FIELDS=3, DIGITS=2, DEBOUNCE=4. Press 1 # 0 # 2 *, each held 20 cycles with 20-cycle gaps → one commit, field_bcd=24'h020001, field_idx=0, busy=0.
- Key 3 held only 3 cycles, then released → no key_strobe, key_code stays 15. Key 3 held 20 cycles → exactly one strobe, key_code=3.
- keypad_in=12'b000000000011 held 20 cycles → no strobe.
- Press 1 2 3 * → field0=8'h23. Press # three times then 5 * → field0=8'h05 (index wrapped to 0).
- Press 4, then drop enable → aborted pulse one cycle later, field_bcd unchanged. TIMEOUT=50 with one press and then idle → aborted 50 cycles after the strobe.
- Assert resetn=0 mid-entry → all outputs 0 at once, key_code=15, no commit or aborted pulse. After release, a new entry works normally.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, pin map and FSM state types.
// Used by the debouncer and by every consumer of decoded key codes.
package keypad_pkg;

    localparam int NUM_KEYS = 12;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'd15;

    // Code carried by each keypad pin, indexed by pin number.
    localparam logic [3:0] KEY_MAP [NUM_KEYS] = '{
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
        4'd7, 4'd8, 4'd9, KEY_STAR, 4'd0, KEY_HASH
    };

    typedef enum logic [1:0] {
        DB_RELEASED,
        DB_PRESS_WAIT,
        DB_HELD,
        DB_RELEASE_WAIT
    } deb_state_t;

    typedef enum logic {
        EN_IDLE,
        EN_ENTRY
    } entry_state_t;

    function automatic logic [3:0] key_decode(
        input logic [NUM_KEYS-1:0] pins
    );
        logic [3:0] code;
        int         hits;
        code = KEY_NONE;
        hits = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (pins[i]) begin
                hits = hits + 1;
                code = KEY_MAP[i];
            end
        end
        return (hits == 1) ? code : KEY_NONE;
    endfunction

endpackage

// File: rtl/keypad_field_entry_if.sv
// Keypad entry bus: keypad pins and enable in, committed fields
// and key/entry status out.
interface keypad_field_entry_if #(
    parameter int NUM_FIELDS = 6,
    parameter int DIGITS     = 2
);
    logic                           enable;
    logic [11:0]                    keypad_in;
    logic [NUM_FIELDS*DIGITS*4-1:0] field_bcd;
    logic [2:0]                     field_idx;
    logic                           busy;
    logic                           key_strobe;
    logic [3:0]                     key_code;
    logic                           commit;
    logic                           aborted;

    modport master (
        output enable,
        output keypad_in,
        input  field_bcd,
        input  field_idx,
        input  busy,
        input  key_strobe,
        input  key_code,
        input  commit,
        input  aborted
    );

    modport slave (
        input  enable,
        input  keypad_in,
        output field_bcd,
        output field_idx,
        output busy,
        output key_strobe,
        output key_code,
        output commit,
        output aborted
    );
endinterface

// File: rtl/keypad_debounce.sv
// Keypad synchroniser and press/release debouncer.
// Emits one strobe per physical press together with its key code.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] keypad_i,
    output logic                strobe_o,
    output logic [3:0]          code_o
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    deb_state_t          st_q, st_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [3:0]          pend_q, pend_d;
    logic [3:0]          code_q, code_d;
    logic                strobe_q, strobe_d;
    logic [3:0]          cur;

    assign cur = key_decode(sync2_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            st_q     <= DB_RELEASED;
            cnt_q    <= '0;
            pend_q   <= KEY_NONE;
            code_q   <= KEY_NONE;
            strobe_q <= 1'b0;
        end else begin
            sync1_q  <= keypad_i;
            sync2_q  <= sync1_q;
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            code_q   <= code_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        code_d   = code_q;
        strobe_d = 1'b0;
        unique case (st_q)
            DB_RELEASED: begin
                if (cur != KEY_NONE) begin
                    st_d   = DB_PRESS_WAIT;
                    cnt_d  = CW'(1);
                    pend_d = cur;
                end
            end
            DB_PRESS_WAIT: begin
                if (cur != pend_q) begin
                    st_d = DB_RELEASED;
                end else if (cnt_q == CW'(DEBOUNCE)) begin
                    st_d     = DB_HELD;
                    strobe_d = 1'b1;
                    code_d   = pend_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DB_HELD: begin
                if (cur == KEY_NONE) begin
                    st_d  = DB_RELEASE_WAIT;
                    cnt_d = CW'(1);
                end
            end
            DB_RELEASE_WAIT: begin
                // A bounce back to a key resumes the hold, no new strobe.
                if (cur != KEY_NONE) begin
                    st_d = DB_HELD;
                end else if (cnt_q == CW'(DEBOUNCE)) begin
                    st_d = DB_RELEASED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: st_d = DB_RELEASED;
        endcase
    end

    assign strobe_o = strobe_q;
    assign code_o   = code_q;

endmodule

// File: rtl/keypad_field_entry.sv
// Multi-field BCD entry engine: digits shift into the current field,
// '#' advances the field, '*' commits all fields atomically.
module keypad_field_entry
    import keypad_pkg::*;
#(
    parameter int NUM_FIELDS = 6,
    parameter int DIGITS     = 2,
    parameter int DEBOUNCE   = 4,
    parameter int TIMEOUT    = 0
) (
    input logic                 clk,
    input logic                 resetn,
    keypad_field_entry_if.slave bus
);

    localparam int FW = DIGITS * 4;
    localparam int BW = NUM_FIELDS * FW;

    logic         strobe;
    logic [3:0]   code;

    entry_state_t st_q, st_d;
    logic [2:0]   idx_q, idx_d;
    logic [BW-1:0] wb_q, wb_d;
    logic [BW-1:0] out_q, out_d;
    logic         commit_q, commit_d;
    logic         abort_q, abort_d;
    logic [31:0]  tmr_q, tmr_d;

    logic [FW-1:0] fld;
    logic          drop;
    logic          expire;
    logic          take;

    keypad_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk      (clk),
        .resetn   (resetn),
        .keypad_i (bus.keypad_in),
        .strobe_o (strobe),
        .code_o   (code)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q     <= EN_IDLE;
            idx_q    <= '0;
            wb_q     <= '0;
            out_q    <= '0;
            commit_q <= 1'b0;
            abort_q  <= 1'b0;
            tmr_q    <= '0;
        end else begin
            st_q     <= st_d;
            idx_q    <= idx_d;
            wb_q     <= wb_d;
            out_q    <= out_d;
            commit_q <= commit_d;
            abort_q  <= abort_d;
            tmr_q    <= tmr_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        idx_d    = idx_q;
        wb_d     = wb_q;
        out_d    = out_q;
        commit_d = 1'b0;
        abort_d  = 1'b0;
        tmr_d    = tmr_q;
        fld      = '0;
        drop     = (st_q == EN_ENTRY) && !bus.enable;
        expire   = (TIMEOUT != 0) && (st_q == EN_ENTRY) && !strobe
                   && (tmr_q >= 32'(TIMEOUT - 1));
        take     = strobe && bus.enable;
        // Abort beats a same-cycle key; a key beats a same-cycle timeout.
        if (drop || expire) begin
            st_d    = EN_IDLE;
            abort_d = 1'b1;
            wb_d    = '0;
            idx_d   = '0;
            tmr_d   = '0;
        end else if (take) begin
            st_d  = EN_ENTRY;
            tmr_d = 32'd1;
            unique case (1'b1)
                (code == KEY_STAR): begin
                    out_d    = wb_q;
                    commit_d = 1'b1;
                    wb_d     = '0;
                    idx_d    = '0;
                    tmr_d    = '0;
                    st_d     = EN_IDLE;
                end
                (code == KEY_HASH): begin
                    idx_d = (idx_q == 3'(NUM_FIELDS - 1))
                            ? 3'd0 : idx_q + 3'd1;
                end
                default: begin
                    for (int i = 0; i < NUM_FIELDS; i++) begin
                        if (idx_q == 3'(i)) begin
                            fld = wb_q[i*FW +: FW];
                            wb_d[i*FW +: FW] = (fld << 4) | FW'(code);
                        end
                    end
                end
            endcase
        end else if ((st_q == EN_ENTRY) && (TIMEOUT != 0)) begin
            tmr_d = tmr_q + 32'd1;
        end
    end

    assign bus.field_bcd  = out_q;
    assign bus.field_idx  = idx_q;
    assign bus.busy       = (st_q == EN_ENTRY);
    assign bus.key_strobe = strobe;
    assign bus.key_code   = code;
    assign bus.commit     = commit_q;
    assign bus.aborted    = abort_q;

endmodule

// File: tb/tb_keypad_field_entry.sv
// Self-checking bench for keypad_field_entry against a field-level
// model of the entry rules.
module tb_keypad_field_entry;

    localparam int NF = 3;
    localparam int DG = 2;
    localparam int DB = 4;
    localparam int W  = NF * DG * 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    keypad_field_entry_if #(.NUM_FIELDS(NF), .DIGITS(DG)) bus ();
    keypad_field_entry_if #(.NUM_FIELDS(NF), .DIGITS(DG)) bus2 ();

    keypad_field_entry #(
        .NUM_FIELDS(NF), .DIGITS(DG), .DEBOUNCE(DB), .TIMEOUT(0)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    keypad_field_entry #(
        .NUM_FIELDS(NF), .DIGITS(DG), .DEBOUNCE(DB), .TIMEOUT(50)
    ) dut2 (
        .clk(clk), .resetn(resetn), .bus(bus2)
    );

    int tests = 0;
    int fails = 0;
    int strobe_cnt = 0;
    int commit_cnt = 0;
    int abort_cnt = 0;

    always @(negedge clk) begin
        if (bus.key_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
        if (bus.commit === 1'b1)     commit_cnt <= commit_cnt + 1;
        if (bus.aborted === 1'b1)    abort_cnt <= abort_cnt + 1;
    end

    // Reference model: fields as integers, digits shifted in base 16.
    int m_wb [NF];
    int m_out[NF];
    int m_idx;
    bit m_busy;
    bit m_en;
    int m_commits;
    int m_aborts;

    function automatic void m_clear();
        for (int i = 0; i < NF; i++) m_wb[i] = 0;
        m_idx  = 0;
        m_busy = 0;
    endfunction

    function automatic void m_key(input int c);
        if (!m_en) return;
        if (c == 10) begin
            for (int i = 0; i < NF; i++) m_out[i] = m_wb[i];
            m_commits++;
            m_clear();
        end else if (c == 11) begin
            m_idx  = (m_idx + 1) % NF;
            m_busy = 1;
        end else begin
            m_wb[m_idx] = (m_wb[m_idx] * 16 + c) % (1 << (4 * DG));
            m_busy = 1;
        end
    endfunction

    function automatic void m_abort();
        if (m_busy) begin
            m_aborts++;
            m_clear();
        end
    endfunction

    function automatic logic [W-1:0] pack();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NF; i++) r = r | (W'(m_out[i]) << (i * DG * 4));
        return r;
    endfunction

    function automatic logic [11:0] pat_of(input int c);
        logic [11:0] p;
        p = '0;
        if (c == 0)       p[10] = 1'b1;
        else if (c <= 9)  p[c-1] = 1'b1;
        else if (c == 10) p[9] = 1'b1;
        else              p[11] = 1'b1;
        return p;
    endfunction

    task automatic press(input logic [11:0] p, input int hold);
        @(negedge clk);
        bus.keypad_in = p;
        repeat (hold) @(negedge clk);
        bus.keypad_in = '0;
        repeat (20) @(negedge clk);
    endtask

    task automatic do_key(input int c);
        press(pat_of(c), 20);
        m_key(c);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.enable = 1'b1;
        bus.keypad_in = '0;
        bus2.enable = 1'b1;
        bus2.keypad_in = '0;
        m_en = 1; m_commits = 0; m_aborts = 0;
        m_clear();
        for (int i = 0; i < NF; i++) m_out[i] = 0;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.field_bcd !== '0) begin
            fails++; $display("FAIL reset_field_bcd got %h want 0", bus.field_bcd);
        end
        tests++;
        if (bus.field_idx !== 3'd0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL reset_idx_busy got %0d/%b want 0/0", bus.field_idx, bus.busy);
        end
        tests++;
        if (bus.key_code !== 4'd15) begin
            fails++; $display("FAIL reset_key_code got %0d want 15", bus.key_code);
        end
        tests++;
        if (bus.key_strobe !== 1'b0 || bus.commit !== 1'b0 || bus.aborted !== 1'b0) begin
            fails++; $display("FAIL reset_pulses got %b%b%b want 000", bus.key_strobe, bus.commit, bus.aborted);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_debounce();
        int s0, lat;
        s0 = strobe_cnt;
        press(pat_of(3), 3);
        tests++;
        if (strobe_cnt !== s0) begin
            fails++; $display("FAIL short_press strobes got %0d want 0", strobe_cnt - s0);
        end
        tests++;
        if (bus.key_code !== 4'd15) begin
            fails++; $display("FAIL short_press key_code got %0d want 15", bus.key_code);
        end
        press(12'b000000000011, 20);
        tests++;
        if (strobe_cnt !== s0) begin
            fails++; $display("FAIL two_keys strobes got %0d want 0", strobe_cnt - s0);
        end
        lat = -1;
        @(negedge clk);
        bus.keypad_in = pat_of(3);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.key_strobe === 1'b1 && lat < 0) lat = k;
        end
        bus.keypad_in = '0;
        repeat (20) @(negedge clk);
        m_key(3);
        tests++;
        if (lat != DB + 3) begin
            fails++; $display("FAIL strobe_latency got %0d want %0d", lat, DB + 3);
        end
        tests++;
        if (strobe_cnt !== s0 + 1) begin
            fails++; $display("FAIL long_press strobes got %0d want 1", strobe_cnt - s0);
        end
        tests++;
        if (bus.key_code !== 4'd3 || bus.busy !== 1'b1) begin
            fails++; $display("FAIL long_press code/busy got %0d/%b want 3/1", bus.key_code, bus.busy);
        end
        do_key(10);
        tests++;
        if (bus.field_bcd !== pack() || commit_cnt !== m_commits) begin
            fails++; $display("FAIL first_commit got %h/%0d want %h/%0d", bus.field_bcd, commit_cnt, pack(), m_commits);
        end
    endtask

    task automatic test_basic();
        int c0;
        c0 = commit_cnt;
        do_key(1); do_key(11); do_key(0); do_key(11); do_key(2); do_key(10);
        tests++;
        if (commit_cnt !== c0 + 1) begin
            fails++; $display("FAIL basic_commits got %0d want 1", commit_cnt - c0);
        end
        tests++;
        if (bus.field_bcd !== 24'h020001) begin
            fails++; $display("FAIL basic_field_bcd got %h want 020001", bus.field_bcd);
        end
        tests++;
        if (bus.field_idx !== 3'd0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL basic_idle got %0d/%b want 0/0", bus.field_idx, bus.busy);
        end
    endtask

    task automatic test_wrap();
        do_key(1); do_key(2); do_key(3); do_key(10);
        tests++;
        if (bus.field_bcd !== 24'h000023) begin
            fails++; $display("FAIL shift_out got %h want 000023", bus.field_bcd);
        end
        do_key(11); do_key(11); do_key(11);
        tests++;
        if (bus.field_idx !== 3'd0 || bus.busy !== 1'b1) begin
            fails++; $display("FAIL idx_wrap got %0d/%b want 0/1", bus.field_idx, bus.busy);
        end
        do_key(5); do_key(10);
        tests++;
        if (bus.field_bcd !== 24'h000005) begin
            fails++; $display("FAIL wrap_commit got %h want 000005", bus.field_bcd);
        end
    endtask

    task automatic test_enable_abort();
        logic [W-1:0] keep;
        int a0, s0;
        bit seen;
        keep = bus.field_bcd;
        a0 = abort_cnt;
        do_key(4);
        @(negedge clk);
        bus.enable = 1'b0;
        m_en = 0;
        m_abort();
        @(negedge clk);
        tests++;
        if (bus.aborted !== 1'b1) begin
            fails++; $display("FAIL abort_pulse got %b want 1", bus.aborted);
        end
        @(negedge clk);
        tests++;
        if (bus.aborted !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL abort_after got %b/%b want 0/0", bus.aborted, bus.busy);
        end
        tests++;
        if (bus.field_bcd !== keep || abort_cnt !== a0 + 1) begin
            fails++; $display("FAIL abort_keep got %h/%0d want %h/%0d", bus.field_bcd, abort_cnt - a0, keep, 1);
        end
        s0 = strobe_cnt;
        do_key(7);
        tests++;
        if (strobe_cnt !== s0 + 1 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL disabled_key got %0d/%b want 1/0", strobe_cnt - s0, bus.busy);
        end
        bus.enable = 1'b1;
        m_en = 1;
        do_key(4);
        seen = 0;
        @(negedge clk);
        bus.keypad_in = pat_of(5);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!seen && bus.key_strobe === 1'b1) begin
                seen = 1;
                bus.enable = 1'b0;
                m_en = 0;
                m_abort();
            end
        end
        bus.keypad_in = '0;
        repeat (20) @(negedge clk);
        tests++;
        if (!seen || bus.busy !== 1'b0 || abort_cnt !== a0 + 2) begin
            fails++; $display("FAIL abort_vs_key got %b/%b/%0d want 1/0/2", seen, bus.busy, abort_cnt - a0);
        end
        tests++;
        if (bus.field_bcd !== keep) begin
            fails++; $display("FAIL abort_vs_key_bcd got %h want %h", bus.field_bcd, keep);
        end
        bus.enable = 1'b1;
        m_en = 1;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int ks, ka;
        ks = -1;
        ka = -1;
        for (int k = 0; k < 300 && ka < 0; k++) begin
            @(negedge clk);
            if (bus2.key_strobe === 1'b1 && ks < 0) ks = k;
            if (bus2.aborted === 1'b1) ka = k;
            if (ks >= 0 && k == ks + 49) begin
                tests++;
                if (bus2.busy !== 1'b1) begin
                    fails++; $display("FAIL timeout_busy got %b want 1", bus2.busy);
                end
            end
            if (k == 0) bus2.keypad_in = pat_of(6);
            if (k == 20) bus2.keypad_in = '0;
        end
        bus2.keypad_in = '0;
        tests++;
        if (ks < 0 || ka < 0) begin
            fails++; $display("FAIL timeout_seen got strobe %0d abort %0d want both >=0", ks, ka);
        end else if (ka - ks != 50) begin
            fails++; $display("FAIL timeout_delay got %0d want 50", ka - ks);
        end
        @(negedge clk);
        tests++;
        if (bus2.aborted !== 1'b0 || bus2.busy !== 1'b0 || bus2.field_bcd !== '0) begin
            fails++; $display("FAIL timeout_after got %b/%b/%h want 0/0/0", bus2.aborted, bus2.busy, bus2.field_bcd);
        end
    endtask

    task automatic test_random();
        int r, c, s0, hold, a, b;
        bit exp_s;
        logic [11:0] p;
        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 9);
            s0 = strobe_cnt;
            exp_s = 1;
            c = $urandom_range(0, 11);
            if (r == 0) begin
                a = $urandom_range(0, 11);
                b = (a + 1 + $urandom_range(0, 10)) % 12;
                p = '0; p[a] = 1'b1; p[b] = 1'b1;
                press(p, 20);
                exp_s = 0;
            end else if (r == 1) begin
                hold = $urandom_range(1, DB - 1);
                press(pat_of(c), hold);
                exp_s = 0;
            end else if (r == 2) begin
                @(negedge clk);
                bus.enable = 1'b0;
                m_en = 0;
                m_abort();
                do_key(c);
                bus.enable = 1'b1;
                m_en = 1;
                @(negedge clk);
            end else begin
                do_key(c);
            end
            tests++;
            if (strobe_cnt !== s0 + (exp_s ? 1 : 0)) begin
                fails++; $display("FAIL rnd%0d strobes got %0d want %0d", it, strobe_cnt - s0, exp_s);
            end
            tests++;
            if (bus.field_bcd !== pack()) begin
                fails++; $display("FAIL rnd%0d field_bcd got %h want %h", it, bus.field_bcd, pack());
            end
            tests++;
            if (bus.field_idx !== 3'(m_idx) || bus.busy !== m_busy) begin
                fails++; $display("FAIL rnd%0d idx/busy got %0d/%b want %0d/%b", it, bus.field_idx, bus.busy, m_idx, m_busy);
            end
            tests++;
            if (commit_cnt !== m_commits || abort_cnt !== m_aborts) begin
                fails++; $display("FAIL rnd%0d pulses got %0d/%0d want %0d/%0d", it, commit_cnt, abort_cnt, m_commits, m_aborts);
            end
        end
    endtask

    task automatic test_reset_mid();
        int c0, a0;
        do_key(5); do_key(6);
        c0 = commit_cnt;
        a0 = abort_cnt;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        tests++;
        if (bus.field_bcd !== '0 || bus.field_idx !== 3'd0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL midreset_state got %h/%0d/%b want 0/0/0", bus.field_bcd, bus.field_idx, bus.busy);
        end
        tests++;
        if (bus.key_code !== 4'd15 || bus.key_strobe !== 1'b0) begin
            fails++; $display("FAIL midreset_key got %0d/%b want 15/0", bus.key_code, bus.key_strobe);
        end
        m_clear();
        for (int i = 0; i < NF; i++) m_out[i] = 0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (commit_cnt !== c0 || abort_cnt !== a0) begin
            fails++; $display("FAIL midreset_pulses got %0d/%0d want 0/0", commit_cnt - c0, abort_cnt - a0);
        end
        do_key(8); do_key(9); do_key(10);
        tests++;
        if (bus.field_bcd !== 24'h000089 || bus.field_bcd !== pack()) begin
            fails++; $display("FAIL after_reset got %h want 000089", bus.field_bcd);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_debounce();
        test_basic();
        test_wrap();
        test_enable_abort();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
